// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - register file geometry and dump state encoding shared by gpr and trace
package gpr_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/gpr_dump_if.sv
// rtl/gpr_dump_if.sv - (index, value) beat stream produced by the register dump engine
interface gpr_dump_if;
    import gpr_pkg::*;

    logic          dout_valid;
    logic          dout_ready;
    logic [AW-1:0] dout_idx;
    logic [DW-1:0] dout_data;

    modport master (
        output dout_valid,
        output dout_idx,
        output dout_data,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_idx,
        input  dout_data,
        output dout_ready
    );

endinterface

// File: rtl/gpr_dump.sv
// rtl/gpr_dump.sv - sweeps a register index range and streams each (index, value) pair
module gpr_dump
    import gpr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] lo_idx,
    input  logic [AW-1:0] hi_idx,
    input  logic          abort,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    gpr_dump_if.master    dout,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   beat_cnt
);

    dump_state_e   state;
    dump_state_e   state_nxt;
    logic [AW-1:0] cur;
    logic [AW-1:0] last;
    logic [AW-1:0] beat_idx;
    logic [DW-1:0] beat_data;
    logic          hs;

    assign hs = (state == S_SEND) && dout.dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (lo_idx <= hi_idx) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                state_nxt = abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (hs) begin
                    state_nxt = (cur == last) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // An abort landing on the DONE cycle suppresses the completion pulse.
    always_comb begin
        dout.dout_valid = (state == S_SEND);
        busy            = (state != S_IDLE);
        done            = (state == S_DONE) && !abort;
    end

    // cur only moves when entering READ, so it doubles as the held read address.
    assign rf_addr        = cur;
    assign dout.dout_idx  = beat_idx;
    assign dout.dout_data = beat_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= '0;
            last     <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cur      <= lo_idx;
                last     <= hi_idx;
                beat_cnt <= '0;
            end
            if (hs) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (cur != last && !abort) begin
                    cur <= cur + 1'b1;
                end
            end
        end
    end

    // Beat register: sampled at the READ edge, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_idx  <= '0;
            beat_data <= '0;
        end else if (state == S_READ) begin
            beat_idx  <= cur;
            beat_data <= rf_data;
        end
    end

endmodule

// File: tb/tb_gpr_dump.sv
// tb/tb_gpr_dump.sv - directed self-checking bench for gpr_dump
module tb_gpr_dump;
    import gpr_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] lo_idx;
    logic [AW-1:0] hi_idx;
    logic          abort;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic          done;
    logic [AW:0]   beat_cnt;

    gpr_dump_if dif ();

    gpr_dump u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lo_idx   (lo_idx),
        .hi_idx   (hi_idx),
        .abort    (abort),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .dout     (dif.master),
        .busy     (busy),
        .done     (done),
        .beat_cnt (beat_cnt)
    );

    logic [DW-1:0] rf [NREG];
    assign rf_data = rf[rf_addr];

    int            n_cmp;
    int            n_bad;
    int            cyc;
    int            done_cnt;
    int            done_cyc;
    int            last_hs_cyc;
    logic [AW-1:0] q_idx[$];
    logic [DW-1:0] q_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (dif.dout_valid && dif.dout_ready) begin
                q_idx.push_back(dif.dout_idx);
                q_data.push_back(dif.dout_data);
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_idx.delete();
        q_data.delete();
        done_cnt = 0;
    endtask

    task automatic start_dump(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        lo_idx = lo;
        hi_idx = hi;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_beat(input logic [AW-1:0] idx, input int budget);
        int n;
        n = 0;
        while (!(dif.dout_valid && dif.dout_idx == idx) && n < budget) begin
            tick();
            n++;
        end
        check("beat_reach", {dif.dout_valid, dif.dout_idx}, {1'b1, idx});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        done_cnt = 0;
        done_cyc = 0;
        last_hs_cyc = 0;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        dif.dout_ready = 1'b1;
        for (int i = 0; i < NREG; i++) rf[i] = i * 32'h11;

        repeat (3) tick();
        check("rst_valid", dif.dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_idx", dif.dout_idx, 0);
        check("rst_data", dif.dout_data, 0);
        check("rst_rf_addr", rf_addr, 0);
        rst = 1'b1;
        tick();

        // Full sweep, ready held high
        clear_mon();
        start_dump(5'd0, 5'd31);
        check("lat_read_valid", dif.dout_valid, 0);
        check("lat_busy", busy, 1);
        tick();
        check("lat_send_valid", dif.dout_valid, 1);
        check("lat_first_idx", dif.dout_idx, 0);
        wait_idle(200);
        check("full_beats", q_idx.size(), 32);
        for (int i = 0; i < 32 && i < q_idx.size(); i++) begin
            check("full_idx", q_idx[i], i);
            check("full_data", q_data[i], i * 32'h11);
        end
        check("full_done_cnt", done_cnt, 1);
        check("full_done_gap", done_cyc - last_hs_cyc, 1);
        check("full_beat_cnt", beat_cnt, 32);

        // Backpressure on beat 5
        clear_mon();
        start_dump(5'd4, 5'd6);
        wait_beat(5'd5, 20);
        dif.dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", dif.dout_valid, 1);
            check("bp_idx", dif.dout_idx, 5);
            check("bp_data", dif.dout_data, 32'h55);
            check("bp_cnt", beat_cnt, 1);
        end
        dif.dout_ready = 1'b1;
        wait_idle(50);
        check("bp_beats", q_idx.size(), 3);
        for (int i = 0; i < 3 && i < q_idx.size(); i++) begin
            check("bp_seq_idx", q_idx[i], 4 + i);
        end
        check("bp_done_cnt", done_cnt, 1);
        check("bp_beat_cnt", beat_cnt, 3);

        // Empty range goes straight to DONE
        clear_mon();
        start_dump(5'd9, 5'd3);
        check("empty_done", done, 1);
        check("empty_valid", dif.dout_valid, 0);
        tick();
        check("empty_done_low", done, 0);
        check("empty_busy", busy, 0);
        check("empty_beat_cnt", beat_cnt, 0);
        check("empty_beats", q_idx.size(), 0);

        // Top register only, no wrap
        clear_mon();
        start_dump(5'd31, 5'd31);
        wait_idle(50);
        check("top_beats", q_idx.size(), 1);
        if (q_idx.size() > 0) begin
            check("top_idx", q_idx[0], 31);
            check("top_data", q_data[0], 32'h20F);
        end
        check("top_beat_cnt", beat_cnt, 1);
        check("top_rf_addr", rf_addr, 31);
        check("top_done_cnt", done_cnt, 1);

        // Abort with simultaneous handshake on beat 10
        clear_mon();
        start_dump(5'd0, 5'd31);
        wait_beat(5'd10, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", dif.dout_valid, 0);
        check("abort_beat_cnt", beat_cnt, 11);
        repeat (3) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_beats", q_idx.size(), 11);
        check("abort_hold_cnt", beat_cnt, 11);
        clear_mon();
        start_dump(5'd2, 5'd3);
        wait_idle(50);
        check("restart_beats", q_idx.size(), 2);
        if (q_idx.size() > 0) check("restart_first", q_idx[0], 2);
        check("restart_beat_cnt", beat_cnt, 2);

        // Abort together with start in IDLE: start wins
        clear_mon();
        abort = 1'b1;
        start_dump(5'd1, 5'd1);
        abort = 1'b0;
        check("abort_start_busy", busy, 1);
        wait_idle(50);
        check("abort_start_cnt", beat_cnt, 1);

        // Write to r7 on the edge that reads it
        clear_mon();
        start_dump(5'd7, 5'd7);
        check("cw_addr", rf_addr, 7);
        @(posedge clk);
        rf[7] <= 32'hDEAD;
        #1;
        wait_idle(50);
        check("cw_old", (q_data.size() > 0) ? q_data[0] : 32'hX, 32'h77);
        clear_mon();
        start_dump(5'd7, 5'd7);
        wait_idle(50);
        check("cw_new", (q_data.size() > 0) ? q_data[0] : 32'hX, 32'hDEAD);

        // Async reset between edges during SEND
        clear_mon();
        start_dump(5'd0, 5'd31);
        wait_beat(5'd3, 50);
        check("ar_pre_cnt", beat_cnt, 3);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", dif.dout_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_beat_cnt", beat_cnt, 0);
        start = 1'b1;
        lo_idx = 5'd0;
        hi_idx = 5'd5;
        repeat (2) tick();
        check("ar_start_ign", busy, 0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        check("ar_after_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
